board_input_ctrl: RTL and testbench



---
 rtl/board_io_pkg.sv | 16 +
 rtl/board_input_ctrl_debounce_cell.sv | 56 +++++
 rtl/board_input_ctrl.sv | 121 ++++++++++++
 tb/tb_board_input_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared constants for the board input path: mode encoding and default timing.
// Imported by the input controller, the board top and simulation configs.
package board_io_pkg;

  localparam logic MODE_STEP = 1'b0;
  localparam logic MODE_RUN  = 1'b1;

  localparam logic [15:0] DEBOUNCE_CYCLES_DEF = 16'd50000;
  localparam int unsigned DIV_LOG2_DEF        = 15;

  typedef enum logic {
    ST_STEP = MODE_STEP,
    ST_RUN  = MODE_RUN
  } mode_e;

endpackage

// File: rtl/board_input_ctrl_debounce_cell.sv
// One conditioned input: 2-flop synchroniser, stability counter, rising-edge press pulse.
// Latency raw->press is 2 + DEBOUNCE_CYCLES cycles; no backpressure.
module debounce_cell
  import board_io_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic press
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        stable_q, stable_d;
  logic        press_q, press_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // The change must persist for DEBOUNCE_CYCLES consecutive samples.
    if (sync2_q != stable_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    press_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/board_input_ctrl.sv
// Board button/switch conditioning and the CPU clock-enable (free-run or single-step).
// cpu_clk_en is registered, one cycle after its cause; no backpressure.
module board_input_ctrl
  import board_io_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DIV_LOG2        = DIV_LOG2_DEF,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             halt,
  input  logic [1:0]       sw_choice,
  input  logic [4:0]       sw_raddr,
  output logic             cpu_clk_en,
  output logic             run_mode,
  output logic [CNT_W-1:0] step_count,
  output logic [1:0]       choice,
  output logic [4:0]       raddr
);

  logic step_stable, step_press;
  logic run_stable, run_press;
  logic halt_db, halt_press;
  logic unused_db;

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk_in (clk_in), .reset_n(reset_n), .raw(btn_step),
    .stable (step_stable), .press(step_press)
  );

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk_in (clk_in), .reset_n(reset_n), .raw(btn_run),
    .stable (run_stable), .press(run_press)
  );

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_halt (
    .clk_in (clk_in), .reset_n(reset_n), .raw(halt),
    .stable (halt_db), .press(halt_press)
  );

  assign unused_db = ^{step_stable, run_stable, halt_press};

  logic [1:0]          choice_meta_q, choice_meta_d, choice_q, choice_d;
  logic [4:0]          raddr_meta_q, raddr_meta_d, raddr_q, raddr_d;
  mode_e               mode_q, mode_d;
  logic [DIV_LOG2-1:0] div_q, div_d;
  logic                cpu_clk_en_q, cpu_clk_en_d;
  logic [CNT_W-1:0]    step_count_q, step_count_d;

  always_comb begin
    choice_meta_d = sw_choice;
    choice_d      = choice_meta_q;
    raddr_meta_d  = sw_raddr;
    raddr_d       = raddr_meta_q;
    mode_d        = mode_q;
    div_d         = div_q;
    cpu_clk_en_d  = 1'b0;
    step_count_d  = step_count_q;

    case (mode_q)
      ST_STEP: begin
        div_d = '0;
        // A mode toggle wins over a coincident step press.
        if (run_press) begin
          mode_d = ST_RUN;
        end else if (step_press && !halt_db) begin
          cpu_clk_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_press) begin
          mode_d = ST_STEP;
          div_d  = '0;
        end else if (!halt_db) begin
          div_d        = div_q + 1'b1;
          cpu_clk_en_d = &div_q;
        end
      end
      default: begin
        mode_d = ST_STEP;
        div_d  = '0;
      end
    endcase

    if (cpu_clk_en_q) begin
      step_count_d = step_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      choice_meta_q <= '0;
      choice_q      <= '0;
      raddr_meta_q  <= '0;
      raddr_q       <= '0;
      mode_q        <= ST_STEP;
      div_q         <= '0;
      cpu_clk_en_q  <= 1'b0;
      step_count_q  <= '0;
    end else begin
      choice_meta_q <= choice_meta_d;
      choice_q      <= choice_d;
      raddr_meta_q  <= raddr_meta_d;
      raddr_q       <= raddr_d;
      mode_q        <= mode_d;
      div_q         <= div_d;
      cpu_clk_en_q  <= cpu_clk_en_d;
      step_count_q  <= step_count_d;
    end
  end

  assign cpu_clk_en = cpu_clk_en_q;
  assign run_mode   = mode_q;
  assign step_count = step_count_q;
  assign choice     = choice_q;
  assign raddr      = raddr_q;

endmodule

// File: tb/tb_board_input_ctrl.sv
// Directed bench for board_input_ctrl with DEBOUNCE_CYCLES=4, DIV_LOG2=3, CNT_W=16.
// A second narrow-counter instance exercises step_count wrap-around.
module tb_board_input_ctrl;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        btn_step, btn_run, halt;
  logic [1:0]  sw_choice;
  logic [4:0]  sw_raddr;
  logic        cpu_clk_en, run_mode;
  logic [15:0] step_count;
  logic [1:0]  choice;
  logic [4:0]  raddr;

  logic        w_run;
  logic        w_en, w_mode;
  logic [3:0]  w_count;
  logic [1:0]  w_choice;
  logic [4:0]  w_raddr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  board_input_ctrl #(.DEBOUNCE_CYCLES(16'd4), .DIV_LOG2(3), .CNT_W(16)) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .btn_step  (btn_step),
    .btn_run   (btn_run),
    .halt      (halt),
    .sw_choice (sw_choice),
    .sw_raddr  (sw_raddr),
    .cpu_clk_en(cpu_clk_en),
    .run_mode  (run_mode),
    .step_count(step_count),
    .choice    (choice),
    .raddr     (raddr)
  );

  board_input_ctrl #(.DEBOUNCE_CYCLES(16'd4), .DIV_LOG2(1), .CNT_W(4)) u_wrap (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .btn_step  (1'b0),
    .btn_run   (w_run),
    .halt      (1'b0),
    .sw_choice (2'b00),
    .sw_raddr  (5'b00000),
    .cpu_clk_en(w_en),
    .run_mode  (w_mode),
    .step_count(w_count),
    .choice    (w_choice),
    .raddr     (w_raddr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  int pulses[$];
  int exp_pulses[8] = '{15, 23, 31, 39, 47, 85, 93, 101};
  int npul, hit, np;
  bit found;

  initial begin
    reset_n   = 1'b0;
    btn_step  = 1'b1;
    btn_run   = 1'b1;
    halt      = 1'b1;
    sw_choice = 2'b11;
    sw_raddr  = 5'h1F;
    w_run     = 1'b1;
    repeat (4) tick();
    check_eq("rst_cpu_clk_en", cpu_clk_en, 0);
    check_eq("rst_run_mode", run_mode, 0);
    check_eq("rst_step_count", step_count, 0);
    check_eq("rst_choice", choice, 0);
    check_eq("rst_raddr", raddr, 0);

    btn_step  = 1'b0;
    btn_run   = 1'b0;
    halt      = 1'b0;
    sw_choice = 2'b00;
    sw_raddr  = 5'h00;
    w_run     = 1'b0;
    tick();
    reset_n = 1'b1;

    npul = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cpu_clk_en) npul++;
    end
    check_eq("idle_no_pulse", npul, 0);
    check_eq("idle_run_mode", run_mode, 0);

    // Bouncy step press, then a solid hold.
    btn_step = 1'b1; tick();
    btn_step = 1'b0; tick();
    btn_step = 1'b1; tick();
    btn_step = 1'b0; tick();
    btn_step = 1'b1;
    npul = 0;
    hit  = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (cpu_clk_en) begin
        npul++;
        hit = k;
      end
    end
    check_eq("bounce_pulse_count", npul, 1);
    check_eq("bounce_pulse_cycle", hit, 7);
    check_eq("bounce_step_count", step_count, 1);

    btn_step = 1'b0;
    npul = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (cpu_clk_en) npul++;
    end
    check_eq("release_no_pulse", npul, 0);

    // Run mode with an ignored step press, a 30-cycle halt, then back to STEP.
    btn_run = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (cpu_clk_en) pulses.push_back(k);
      if (k == 6)   check_eq("run_mode_before", run_mode, 0);
      if (k == 7)   check_eq("run_mode_entered", run_mode, 1);
      if (k == 102) check_eq("run_mode_still", run_mode, 1);
      if (k == 103) check_eq("run_mode_left", run_mode, 0);
      if (k == 8)   btn_run = 1'b0;
      if (k == 20)  btn_step = 1'b1;
      if (k == 30)  btn_step = 1'b0;
      if (k == 48)  halt = 1'b1;
      if (k == 78)  halt = 1'b0;
      if (k == 96)  btn_run = 1'b1;
      if (k == 106) btn_run = 1'b0;
    end
    check_eq("run_pulse_total", pulses.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_eq("run_pulse_at", (i < pulses.size()) ? pulses[i] : -1, exp_pulses[i]);
    end
    check_eq("run_step_count", step_count, 9);

    // Step press under halt in STEP is dropped and not replayed on release.
    npul = 0;
    halt = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      tick();
      if (cpu_clk_en) npul++;
      if (k == 10) btn_step = 1'b1;
      if (k == 20) btn_step = 1'b0;
      if (k == 30) halt = 1'b0;
    end
    check_eq("halt_step_dropped", npul, 0);

    npul = 0;
    btn_step = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (cpu_clk_en) npul++;
      if (k == 10) btn_step = 1'b0;
    end
    check_eq("clean_step_pulse", npul, 1);
    check_eq("clean_step_count", step_count, 10);

    // Run and step pressed together in STEP: mode flips, step ignored.
    npul = 0;
    btn_run  = 1'b1;
    btn_step = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (cpu_clk_en) npul++;
    end
    check_eq("simul_no_step", npul, 0);
    check_eq("simul_run_mode", run_mode, 1);
    btn_run  = 1'b0;
    btn_step = 1'b0;

    // Asynchronous reset while cpu_clk_en is high.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (cpu_clk_en) found = 1'b1;
    end
    check_eq("reach_run_pulse", found, 1);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_en", cpu_clk_en, 0);
    check_eq("async_rst_count", step_count, 0);
    check_eq("async_rst_mode", run_mode, 0);
    tick();
    reset_n = 1'b1;

    // Switch synchronisers: two cycles, no debounce.
    tick();
    sw_raddr  = 5'h1F;
    sw_choice = 2'b10;
    tick();
    check_eq("raddr_1cyc", raddr, 5'h00);
    tick();
    check_eq("raddr_2cyc", raddr, 5'h1F);
    check_eq("choice_2cyc", choice, 2'b10);

    // Narrow counter wraps after 2^4 pulses.
    w_run = 1'b1;
    np = 0;
    for (int k = 0; k < 200 && np < 15; k++) begin
      tick();
      if (w_en) np++;
    end
    tick();
    check_eq("wrap_before", w_count, 4'd15);
    for (int k = 0; k < 200 && np < 16; k++) begin
      tick();
      if (w_en) np++;
    end
    tick();
    check_eq("wrap_pulses", np, 16);
    check_eq("wrap_to_zero", w_count, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
